cc_gate_logic_pipe: RTL

// - Parametrised, registered successor to the two-input NOR gate: a DATA_WIDTH-wide bitwise logic unit.
// - A per-transaction opcode selects the function: NOR (legacy), AND, OR, NAND, XOR, XNOR, NOT_A or PASS_A.
// - Valid/ready handshake on input and output, with a 2-entry skid buffer so full throughput survives backpressure.
// - Sits between datapath stages in lab designs; also counts completed results and flags all-zero results.

---
 rtl/cc_gate_logic_pkg.sv | 24 ++
 rtl/cc_gate_logic_core.sv | 33 +++
 rtl/cc_gate_logic_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cc_gate_logic_pkg.sv
// Shared opcode encodings and occupancy states for the registered bitwise logic unit.
package cc_gate_logic_pkg;

    localparam int OP_WIDTH = 3;

    typedef logic [OP_WIDTH-1:0] op_t;

    localparam op_t OP_NOR    = 3'd0;
    localparam op_t OP_AND    = 3'd1;
    localparam op_t OP_OR     = 3'd2;
    localparam op_t OP_NAND   = 3'd3;
    localparam op_t OP_XOR    = 3'd4;
    localparam op_t OP_XNOR   = 3'd5;
    localparam op_t OP_NOT_A  = 3'd6;
    localparam op_t OP_PASS_A = 3'd7;

    // Number of valid entries held between the output and skid registers.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/cc_gate_logic_core.sv
// Bitwise logic function selected by a 3-bit opcode, plus an all-zero flag.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the result is captured.
import cc_gate_logic_pkg::*;

module cc_gate_logic_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  op_t                   op,
    output logic [DATA_WIDTH-1:0] z,
    output logic                  zero
);

    always_comb begin
        z = '0;
        case (op)
            OP_NOR:    z = ~(a | b);
            OP_AND:    z = a & b;
            OP_OR:     z = a | b;
            OP_NAND:   z = ~(a & b);
            OP_XOR:    z = a ^ b;
            OP_XNOR:   z = ~(a ^ b);
            OP_NOT_A:  z = ~a;
            OP_PASS_A: z = a;
            default:   z = '0;
        endcase
    end

    assign zero = (z == '0);

endmodule

// File: rtl/cc_gate_logic_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides and a drain counter.
// Latency: 1 cycle from accept to valid result.
// Backpressure: 2-entry skid (OUT + SKID); ready is registered and drops only when both entries are full.
import cc_gate_logic_pkg::*;

module cc_gate_logic_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CC_GateLOGIC_CLOCK_50,
    input  logic                  CC_GateLOGIC_RESET_InLow,
    input  logic [DATA_WIDTH-1:0] CC_GateLOGIC_a_In,
    input  logic [DATA_WIDTH-1:0] CC_GateLOGIC_b_In,
    input  logic [OP_WIDTH-1:0]   CC_GateLOGIC_op_In,
    input  logic                  CC_GateLOGIC_valid_In,
    output logic                  CC_GateLOGIC_ready_Out,
    output logic [DATA_WIDTH-1:0] CC_GateLOGIC_z_Out,
    output logic                  CC_GateLOGIC_zero_Out,
    output logic                  CC_GateLOGIC_valid_Out,
    input  logic                  CC_GateLOGIC_ready_In,
    output logic [CNT_WIDTH-1:0]  CC_GateLOGIC_count_Out
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] z;
        logic                  zero;
    } entry_t;

    occ_t                 occState;
    occ_t                 occNext;
    entry_t               outEntry;
    entry_t               skidEntry;
    entry_t               newEntry;
    logic                 readyReg;
    logic [CNT_WIDTH-1:0] drainCount;

    logic outVld;
    logic skidVld;
    logic accept;
    logic drain;
    logic loadOut;
    logic loadOutFromSkid;
    logic loadSkid;

    cc_gate_logic_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uCore (
        .a    (CC_GateLOGIC_a_In),
        .b    (CC_GateLOGIC_b_In),
        .op   (CC_GateLOGIC_op_In),
        .z    (newEntry.z),
        .zero (newEntry.zero)
    );

    assign outVld  = (occState != OCC_EMPTY);
    assign skidVld = (occState == OCC_TWO);
    assign accept  = CC_GateLOGIC_valid_In & readyReg;
    assign drain   = outVld & CC_GateLOGIC_ready_In;

    // readyReg is low in TWO, so an accept can never coincide with a full skid.
    always_comb begin
        occNext         = occState;
        loadOut         = 1'b0;
        loadOutFromSkid = 1'b0;
        loadSkid        = 1'b0;
        case (occState)
            OCC_EMPTY: begin
                if (accept) begin
                    occNext = OCC_ONE;
                    loadOut = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    loadOut = 1'b1;
                end else if (accept) begin
                    occNext  = OCC_TWO;
                    loadSkid = 1'b1;
                end else if (drain) begin
                    occNext = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (drain) begin
                    occNext         = OCC_ONE;
                    loadOutFromSkid = 1'b1;
                end
            end
            default: occNext = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge CC_GateLOGIC_CLOCK_50) begin
        if (!CC_GateLOGIC_RESET_InLow) begin
            occState   <= OCC_EMPTY;
            outEntry   <= '0;
            skidEntry  <= '0;
            readyReg   <= 1'b0;
            drainCount <= '0;
        end else begin
            occState <= occNext;
            readyReg <= (occNext != OCC_TWO);
            if (loadOut) begin
                outEntry <= newEntry;
            end else if (loadOutFromSkid) begin
                outEntry <= skidEntry;
            end
            if (loadSkid) begin
                skidEntry <= newEntry;
            end
            if (drain) begin
                drainCount <= drainCount + CNT_WIDTH'(1);
            end
        end
    end

    assign CC_GateLOGIC_ready_Out = readyReg;
    assign CC_GateLOGIC_valid_Out = outVld;
    assign CC_GateLOGIC_z_Out     = outEntry.z;
    assign CC_GateLOGIC_zero_Out  = outEntry.zero;
    assign CC_GateLOGIC_count_Out = drainCount;

    // skidVld documents the skid occupancy; ready mirrors its complement outside reset.
    logic unusedSkidVld;
    assign unusedSkidVld = skidVld;

endmodule
